data_bus_responder: RTL
=======================

// Module: data_bus_responder
// PURPOSE
//  Data-side responder for the riscv_pipeline load/store port; drop-in for data_mem.
//  Serves a byte-masked word RAM plus a small MMIO page:
//   - tohost FIFO, drained by the bench/host through a valid/ready handshake
//   - free-running cycle timer with compare register and level interrupt
//  The CPU has no stall input, so all reads complete with zero wait states.
// PARAMETERS
//  RAM_WORDS   1024   RAM depth in 32-bit words; RAM decodes 0x0 .. RAM_WORDS*4-1
//  FIFO_DEPTH  4      tohost FIFO entries (power of two, >=2)
//  MMIO_BASE   32'hFFFF_0000  base of the 16-byte MMIO page
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous, active-high reset
//  adr            in   32  byte address from CPU; adr[1:0] ignored (word access)
//  d_in           in   32  store data from CPU
//  mrd            in   1   load strobe
//  mwr            in   1   store strobe
//  data_out_mask  in   4   byte enables for stores; bit i enables d_in[8i+7:8i]
//  d_out          out  32  load data to CPU, combinational
//  host_valid     out  1   tohost FIFO head is valid
//  host_data      out  32  tohost FIFO head word
//  host_ready     in   1   host accepts head when host_valid && host_ready
//  timer_irq      out  1   level: mtime >= mtimecmp
//  access_err     out  1   sticky unmapped-access flag (0 unless ACCESS_ERR_EN)
// BEHAVIOUR
//  Reset: fifo empty, host_valid=0, host_data=0, mtime=0, mtimecmp=32'hFFFF_FFFF,
//   overflow=0, timer_irq=0, access_err=0. RAM contents are not cleared.
//  Reads: d_out = selected word when mrd=1, else 32'h0; no clock latency.
//  Writes: committed on posedge clk when mwr=1; only masked bytes change.
//   mrd && mwr to the same word: d_out returns the pre-write value that cycle.
//  MMIO map (offsets from MMIO_BASE):
//   +0x0 TOHOST   W: push d_in (mask ignored) | R: {28'b0, count[3:0]}
//   +0x4 MTIME    R: counter, +1 every cycle, wraps 0xFFFF_FFFF->0 | W: ignored
//   +0x8 MTIMECMP R/W, byte-masked
//   +0xC STATUS   R: {29'b0, overflow, timer_irq, full} | W: bit2=1 clears overflow
//  FIFO:
//   - push when full -> word dropped, overflow set at that edge
//   - push+pop same cycle when full -> both accepted, count unchanged
//   - push into empty -> host_valid rises the next cycle (no fall-through)
//   - host_data holds the head word; it is stable while host_valid && !host_ready
//   - count saturates in range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH
//  timer_irq: registered compare, updates one cycle after mtime/mtimecmp change.
//   Writing mtimecmp > mtime deasserts the interrupt on the following cycle.
//  Unmapped address (neither RAM nor MMIO page): handled per CONFIGURATION.
//  rst mid-operation: FIFO contents discarded, all registers return to reset values.
// CONFIGURATION
//  ACCESS_ERR_EN defined:
//   - unmapped load returns 32'hDEAD_BEEF
//   - unmapped load/store sets access_err at the next edge; cleared only by rst
//  ACCESS_ERR_EN undefined:
//   - unmapped load returns 32'h0, unmapped store is ignored
//   - access_err tied 0
// TESTING
//  1 mwr adr=0x10 d_in=0xAABBCCDD mask=4'b0101, then mrd adr=0x10 (RAM was 0)
//    -> d_out=0x00BB00DD
//  2 push 5 words to TOHOST, host_ready=0
//    -> count=4, STATUS=0b101; 5th word dropped
//    then host_ready=1 -> 4 words pop in push order; STATUS write 0x4 -> overflow=0
//  3 FIFO full; push and pop in the same cycle
//    -> count stays 4, new word becomes last entry, overflow stays 0
//  4 write MTIMECMP=20 after reset -> timer_irq=1 at cycle 21
//    write MTIMECMP=0xFFFF_FFFF -> timer_irq=0 one cycle later
//  5 mrd adr=0x8000_0000: with ACCESS_ERR_EN -> d_out=0xDEADBEEF, access_err=1 and sticky;
//    without ACCESS_ERR_EN -> d_out=0, access_err=0
//  6 assert rst with FIFO count=3 and mtime=50
//    -> host_valid=0, count=0, mtime=0, RAM data preserved

Source files
------------

// File: rtl/data_bus_responder.sv
// ============================================================================
// data_bus_responder
//   Data-side responder for the riscv_pipeline load/store port (drop-in for
//   data_mem). It serves a byte-masked word RAM and a 16-byte MMIO page.
//   The MMIO page holds a tohost FIFO, a free-running timer, a timer compare
//   register and a status register. Loads complete combinationally with zero
//   wait states because the CPU has no stall input.
//
//   MMIO map (offsets from MMIO_BASE):
//     +0x0 TOHOST   W: push d_in          R: {28'b0, count[3:0]}
//     +0x4 MTIME    R: cycle counter      W: ignored
//     +0x8 MTIMECMP R/W, byte-masked
//     +0xC STATUS   R: {29'b0, overflow, timer_irq, full}  W: bit2 clears overflow
//
//   Optional feature macro: ACCESS_ERR_EN
//     defined   : an unmapped load returns 32'hDEAD_BEEF, and any unmapped
//                 access sets the sticky access_err flag
//     undefined : an unmapped load returns 0, an unmapped store is ignored,
//                 and access_err is tied to 0
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   asynchronous active-high reset
//   adr           in  32   byte address (adr[1:0] ignored)
//   d_in          in  32   store data
//   mrd           in   1   load strobe
//   mwr           in   1   store strobe
//   data_out_mask in   4   store byte enables
//   d_out         out 32   load data (combinational, 0 when mrd=0)
//   host_valid    out  1   tohost FIFO head valid
//   host_data     out 32   tohost FIFO head word
//   host_ready    in   1   host accepts the head word
//   timer_irq     out  1   registered level: mtime >= mtimecmp
//   access_err    out  1   sticky unmapped-access flag
// ============================================================================
module data_bus_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic [31:0] d_in,
    input  logic        mrd,
    input  logic        mwr,
    input  logic [3:0]  data_out_mask,
    output logic [31:0] d_out,
    output logic        host_valid,
    output logic [31:0] host_data,
    input  logic        host_ready,
    output logic        timer_irq,
    output logic        access_err
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

    localparam logic [1:0] OFF_TOHOST = 2'd0;
    localparam logic [1:0] OFF_MTIME  = 2'd1;
    localparam logic [1:0] OFF_MTCMP  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // ---------------- address decode ----------------
    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] word_idx;

    assign ram_hit  = ({1'b0, adr} < RAM_BYTES);
    assign mmio_hit = (adr[31:4] == MMIO_BASE[31:4]);
    assign word_idx = adr[AW+1:2];

    // ---------------- storage (never reset) ----------------
    logic [31:0] mem_q  [RAM_WORDS];
    logic [31:0] fifo_q [FIFO_DEPTH];

    // ---------------- control state ----------------
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   mtime_q, mtime_d;
    logic [31:0]   mtimecmp_q, mtimecmp_d;
    logic          irq_q, irq_d;

    logic full, push_req, pop, push_acc;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign push_req = mwr && mmio_hit && (adr[3:2] == OFF_TOHOST);
    assign pop      = (count_q != '0) && host_ready;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign push_acc = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = mtime_q + 32'd1;
        // Compare uses the current registers, so the level lags by one cycle.
        irq_d      = (mtime_q >= mtimecmp_q);

        if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_req && !push_acc)
            ovf_d = 1'b1;
        else if (mwr && mmio_hit && (adr[3:2] == OFF_STATUS) && d_in[2])
            ovf_d = 1'b0;

        if (mwr && mmio_hit && (adr[3:2] == OFF_MTCMP)) begin
            for (int i = 0; i < 4; i++) begin
                if (data_out_mask[i]) mtimecmp_d[8*i +: 8] = d_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            mtime_q    <= 32'h0;
            mtimecmp_q <= 32'hFFFF_FFFF;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mwr && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (data_out_mask[i]) mem_q[word_idx][8*i +: 8] <= d_in[8*i +: 8];
            end
        end
        if (push_acc) fifo_q[wr_ptr_q] <= d_in;
    end

`ifdef ACCESS_ERR_EN
    logic unmapped;
    logic err_q;

    assign unmapped = !ram_hit && !mmio_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            err_q <= 1'b0;
        else if ((mrd || mwr) && unmapped)  err_q <= 1'b1;
    end

    assign access_err = err_q;
`else
    assign access_err = 1'b0;
`endif

    // ---------------- load data mux ----------------
    always_comb begin
        d_out = 32'h0;
        if (mrd) begin
            if (ram_hit) begin
                d_out = mem_q[word_idx];
            end else if (mmio_hit) begin
                case (adr[3:2])
                    OFF_TOHOST: d_out = {28'b0, 4'(count_q)};
                    OFF_MTIME:  d_out = mtime_q;
                    OFF_MTCMP:  d_out = mtimecmp_q;
                    default:    d_out = {29'b0, ovf_q, irq_q, full};
                endcase
            end else begin
`ifdef ACCESS_ERR_EN
                d_out = 32'hDEAD_BEEF;
`else
                d_out = 32'h0;
`endif
            end
        end
    end

    assign host_valid = (count_q != '0);
    assign host_data  = (count_q != '0) ? fifo_q[rd_ptr_q] : 32'h0;
    assign timer_irq  = irq_q;

endmodule
